// File: rtl/tournament_selector_table.sv
// tournament_selector_table
//   PC-indexed table of 2-bit tournament chooser states (00 SL, 01 WL, 10 WG, 11 SG).
//   Fetch side reads the chooser for if_pc and picks the local or global prediction.
//   Memory side writes back the updated chooser state from the tournament FSM.
//   After reset, the table is swept to WL (01) one entry per cycle before lookups are valid.
// Ports
//   clk, rst        clock, synchronous active-high reset
//   if_pc           fetch PC (index = pc[IDX_BITS+1:2])
//   if_local_pred   local predictor counter for if_pc
//   if_global_pred  global predictor counter for if_pc
//   if_sel          chooser state for if_pc (bypassed / forced during init)
//   if_taken        final predicted direction
//   mem_update      write strobe for a resolved branch
//   mem_pc          PC of the resolved branch
//   mem_sel_new     updated chooser state to store
//   ready           table initialised, lookups valid
module tournament_selector_table #(
  parameter int unsigned IDX_BITS = 6,
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] if_pc,
  input  logic [1:0]          if_local_pred,
  input  logic [1:0]          if_global_pred,
  output logic [1:0]          if_sel,
  output logic                if_taken,
  input  logic                mem_update,
  input  logic [PC_WIDTH-1:0] mem_pc,
  input  logic [1:0]          mem_sel_new,
  output logic                ready
);

  localparam int unsigned Depth = 2 ** IDX_BITS;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e              state_q;
  logic [IDX_BITS-1:0] init_ptr_q;
  logic                ready_q;
  logic [1:0]          table_q [Depth];

  logic [IDX_BITS-1:0] if_idx;
  logic [IDX_BITS-1:0] mem_idx;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign mem_idx = mem_pc[IDX_BITS+1:2];

  // Word-offset bits and bits above the index are deliberately ignored (no tag check).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[PC_WIDTH-1:IDX_BITS+2], if_pc[1:0],
                            mem_pc[PC_WIDTH-1:IDX_BITS+2], mem_pc[1:0],
                            if_local_pred[0], if_global_pred[0]};

  // Controller: INIT sweeps every entry once, then RUN until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StInit;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_ptr_q <= init_ptr_q + 1'b1;
          if (init_ptr_q == IDX_BITS'(Depth - 1)) begin
            state_q <= StRun;
            ready_q <= 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StInit;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; the INIT sweep is what removes X from every entry.
  // Write-backs arriving during INIT are dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StInit) begin
        table_q[init_ptr_q] <= 2'b01;
      end else if (mem_update) begin
        table_q[mem_idx] <= mem_sel_new;
      end
    end
  end

  // Lookup with same-cycle bypass so a branch resolving now is seen by fetch now.
  always_comb begin
    if_sel = table_q[if_idx];
    if (state_q == StInit) begin
      if_sel = 2'b01;
    end else if (mem_update && (mem_idx == if_idx)) begin
      if_sel = mem_sel_new;
    end
  end

  assign if_taken = if_sel[1] ? if_global_pred[1] : if_local_pred[1];
  assign ready    = ready_q;

endmodule

// File: tb/tb_tournament_selector_table.sv
module tb_tournament_selector_table;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [1:0]  if_local_pred;
  logic [1:0]  if_global_pred;
  logic [1:0]  if_sel;
  logic        if_taken;
  logic        mem_update;
  logic [31:0] mem_pc;
  logic [1:0]  mem_sel_new;
  logic        ready;

  int total = 0;
  int bad   = 0;

  // Reference model: entries as plain ints, init progress as a count of swept entries.
  int m_tab [64];
  int m_swept;
  bit m_run;

  always #5 clk = ~clk;

  tournament_selector_table #(
    .IDX_BITS(6),
    .PC_WIDTH(32)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc         (if_pc),
    .if_local_pred (if_local_pred),
    .if_global_pred(if_global_pred),
    .if_sel        (if_sel),
    .if_taken      (if_taken),
    .mem_update    (mem_update),
    .mem_pc        (mem_pc),
    .mem_sel_new   (mem_sel_new),
    .ready         (ready)
  );

  function automatic int slot(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic logic [1:0] exp_sel();
    if (!m_run) return 2'b01;
    if (mem_update && slot(mem_pc) == slot(if_pc)) return mem_sel_new;
    return 2'(m_tab[slot(if_pc)]);
  endfunction

  function automatic logic exp_taken();
    logic [1:0] s;
    s = exp_sel();
    return (s >= 2) ? (if_global_pred >= 2) : (if_local_pred >= 2);
  endfunction

  // Advance the model by one clock edge using current inputs, then step the DUT.
  task automatic tick();
    if (rst) begin
      m_run   = 1'b0;
      m_swept = 0;
    end else if (!m_run) begin
      m_tab[m_swept] = 1;
      m_swept++;
      if (m_swept == 64) m_run = 1'b1;
    end else if (mem_update) begin
      m_tab[slot(mem_pc)] = int'(mem_sel_new);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name, output int cycles);
    cycles = 0;
    while (!ready && cycles < 200) begin
      tick();
      cycles++;
    end
    total++;
    if (!ready) begin
      bad++;
      $display("FAIL %s: ready never rose within %0d cycles", name, cycles);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if_pc          = $urandom;
      if_local_pred  = 2'($urandom);
      if_global_pred = 2'($urandom);
      #1;
      total++;
      if (ready !== 1'b0 || if_sel !== 2'b01 || if_taken !== if_local_pred[1]) begin
        bad++;
        $display("FAIL reset_init c=%0d: ready=%b sel=%b taken=%b want ready=0 sel=01 taken=%b",
                 c, ready, if_sel, if_taken, if_local_pred[1]);
      end
      tick();
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: ready=%b want 1 after 64 cycles", ready);
    end
    for (int i = 0; i < 64; i++) begin
      if_pc = (32'($urandom) << 8) | 32'(i * 4) | 32'($urandom_range(0, 3));
      #1;
      total++;
      if (if_sel !== 2'b01) begin
        bad++;
        $display("FAIL reset_sweep idx=%0d: sel=%b want 01", i, if_sel);
      end
    end
  endtask

  task automatic test_write_read();
    if_pc       = 32'h0;
    mem_update  = 1'b1;
    mem_pc      = 32'h40;
    mem_sel_new = 2'b11;
    tick();
    mem_update     = 1'b0;
    if_pc          = 32'h40;
    if_local_pred  = 2'b00;
    if_global_pred = 2'b10;
    #1;
    total++;
    if (if_sel !== 2'b11 || if_taken !== 1'b1) begin
      bad++;
      $display("FAIL write_read: sel=%b taken=%b want sel=11 taken=1", if_sel, if_taken);
    end
  endtask

  task automatic test_bypass();
    if_pc       = 32'h88;
    mem_pc      = 32'h88;
    mem_update  = 1'b1;
    mem_sel_new = 2'b10;
    #1;
    total++;
    if (if_sel !== 2'b10) begin
      bad++;
      $display("FAIL bypass_same_cycle: sel=%b want 10", if_sel);
    end
    tick();
    mem_update = 1'b0;
    #1;
    total++;
    if (if_sel !== 2'b10) begin
      bad++;
      $display("FAIL bypass_next_cycle: sel=%b want 10", if_sel);
    end
  endtask

  task automatic test_alias();
    mem_update  = 1'b1;
    mem_pc      = 32'h004;
    mem_sel_new = 2'b11;
    if_pc       = 32'h0;
    tick();
    mem_update = 1'b0;
    if_pc      = 32'h104;
    #1;
    total++;
    if (if_sel !== 2'b11) begin
      bad++;
      $display("FAIL alias_a: sel=%b want 11", if_sel);
    end
    mem_update  = 1'b1;
    mem_pc      = 32'h104;
    mem_sel_new = 2'b00;
    if_pc       = 32'h0;
    tick();
    mem_update = 1'b0;
    if_pc      = 32'h004;
    #1;
    total++;
    if (if_sel !== 2'b00) begin
      bad++;
      $display("FAIL alias_b: sel=%b want 00", if_sel);
    end
  endtask

  task automatic test_init_drop();
    int n;
    rst = 1'b1;
    tick();
    rst         = 1'b0;
    mem_update  = 1'b1;
    mem_pc      = 32'h10;
    mem_sel_new = 2'b11;
    if_pc       = 32'h0;
    wait_ready("init_drop_ready", n);
    mem_update = 1'b0;
    if_pc      = 32'h10;
    #1;
    total++;
    if (if_sel !== 2'b01) begin
      bad++;
      $display("FAIL init_drop: sel=%b want 01", if_sel);
    end
  endtask

  task automatic test_rst_mid_run();
    int n;
    mem_update  = 1'b1;
    mem_pc      = 32'h20;
    mem_sel_new = 2'b11;
    tick();
    mem_update = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if_pc = $urandom;
      tick();
    end
    if_pc = 32'h20;
    #1;
    total++;
    if (if_sel !== 2'b11) begin
      bad++;
      $display("FAIL mid_run_hold: sel=%b want 11", if_sel);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_run_rst: ready=%b want 0", ready);
    end
    wait_ready("mid_run_ready", n);
    total++;
    if (n != 64) begin
      bad++;
      $display("FAIL mid_run_sweep_len: cycles=%0d want 64", n);
    end
    if_pc = 32'h20;
    #1;
    total++;
    if (if_sel !== 2'b01) begin
      bad++;
      $display("FAIL mid_run_reinit: sel=%b want 01", if_sel);
    end
  endtask

  task automatic test_random();
    logic [1:0] es;
    logic       et;
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 299) == 0);
      if_pc          = $urandom;
      if_local_pred  = 2'($urandom);
      if_global_pred = 2'($urandom);
      mem_update     = $urandom_range(0, 1);
      mem_pc         = $urandom;
      if ($urandom_range(0, 3) == 0) mem_pc = {mem_pc[31:8], if_pc[7:2], mem_pc[1:0]};
      mem_sel_new    = 2'($urandom);
      #1;
      es = exp_sel();
      et = exp_taken();
      total++;
      if (if_sel !== es || if_taken !== et || ready !== m_run) begin
        bad++;
        $display("FAIL random c=%0d: sel=%b taken=%b ready=%b want sel=%b taken=%b ready=%b",
                 c, if_sel, if_taken, ready, es, et, m_run);
      end
      tick();
    end
  endtask

  initial begin
    rst            = 1'b1;
    if_pc          = '0;
    if_local_pred  = '0;
    if_global_pred = '0;
    mem_update     = 1'b0;
    mem_pc         = '0;
    mem_sel_new    = '0;
    m_run          = 1'b0;
    m_swept        = 0;
    for (int i = 0; i < 64; i++) m_tab[i] = 0;
    test_reset();
    test_write_read();
    test_bypass();
    test_alias();
    test_init_drop();
    test_rst_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
